// File: rtl/vend_pkg.sv
// Shared types, constants and helpers for the vending transaction controller.
// Coin values and parameter sanity checks live here so every block agrees.
package vend_pkg;

    localparam int unsigned COIN_UNIT = 5;

    typedef enum logic [3:0] {
        S_MONEY_EATER     = 4'b0001,
        S_DRINK_OUTER     = 4'b0010,
        S_MONEY_OUTER     = 4'b0100,
        S_MONEY_OUTER_ALL = 4'b1000
    } state_t;

    function automatic logic [6:0] coin_value(input logic [1:0] code);
        case (code)
            2'b00:   return 7'd5;
            2'b01:   return 7'd10;
            2'b10:   return 7'd20;
            default: return 7'd50;
        endcase
    endfunction

    // Every credit change must stay on the COIN_UNIT grid and fit the register.
    function automatic bit params_ok(
        input int unsigned drink,
        input int unsigned max_credit,
        input int unsigned credit_w
    );
        return (drink % COIN_UNIT == 0) && (max_credit % COIN_UNIT == 0)
            && (10 % COIN_UNIT == 0) && (20 % COIN_UNIT == 0)
            && (50 % COIN_UNIT == 0) && (drink > 0) && (drink <= max_credit)
            && (credit_w < 32) && (max_credit < (32'd1 << credit_w));
    endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter: reload forces LOAD, enable counts toward zero.
// expired is high while the count sits at zero.
module vend_timer #(
    parameter int unsigned LOAD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LOAD + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            count <= W'(LOAD);
        end else if (enable && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: coin credit, dispense handshake,
// change/refund payout one unit coin at a time.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned DRINK_VALUE  = 25,
    parameter int unsigned MAX_CREDIT   = 100,
    parameter int unsigned CREDIT_W     = 8,
    parameter int unsigned IDLE_TIMEOUT = 1000,
    parameter int unsigned DISP_TIMEOUT = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                buy,
    input  logic                cancel,
    output logic                disp_req,
    input  logic                disp_ack,
    output logic                chg_req,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic [3:0]          S_state,
    output logic                coin_reject,
    output logic                vend_done,
    output logic                disp_fault
);

    if (!params_ok(DRINK_VALUE, MAX_CREDIT, CREDIT_W)) begin : g_param_err
        $error("vend_ctrl: inconsistent credit parameters");
    end

    localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] DRINK_C = CREDIT_W'(DRINK_VALUE);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(COIN_UNIT);

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic [CREDIT_W:0]   sum;
    logic                disp_req_n, chg_req_n;
    logic                coin_reject_n, vend_done_n, disp_fault_n;
    logic                idle_reload, idle_expired, disp_expired;

    assign sum = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin_code));

    vend_timer #(.LOAD(IDLE_TIMEOUT)) u_idle (
        .clk     (clk),
        .rst     (rst),
        .reload  (idle_reload),
        .enable  (1'b1),
        .expired (idle_expired)
    );

    vend_timer #(.LOAD(DISP_TIMEOUT)) u_disp (
        .clk     (clk),
        .rst     (rst),
        .reload  (!disp_req),
        .enable  (disp_req),
        .expired (disp_expired)
    );

    always_comb begin
        state_n       = state;
        credit_n      = credit;
        coin_reject_n = 1'b0;
        vend_done_n   = 1'b0;
        disp_fault_n  = 1'b0;
        idle_reload   = 1'b1;
        case (state)
            S_MONEY_EATER: begin
                idle_reload = (credit == '0) || coin_valid || buy || cancel;
                if (cancel && credit != '0) begin
                    state_n       = S_MONEY_OUTER_ALL;
                    coin_reject_n = coin_valid;
                end else if (buy && credit >= DRINK_C) begin
                    state_n       = S_DRINK_OUTER;
                    coin_reject_n = coin_valid;
                end else if (coin_valid) begin
                    if (sum <= MAX_C) credit_n = sum[CREDIT_W-1:0];
                    else              coin_reject_n = 1'b1;
                end else if (idle_expired && !idle_reload) begin
                    state_n = S_MONEY_OUTER_ALL;
                end
            end
            S_DRINK_OUTER: begin
                coin_reject_n = coin_valid;
                if (disp_req && disp_ack) begin
                    credit_n    = credit - DRINK_C;
                    vend_done_n = 1'b1;
                    state_n     = (credit != DRINK_C) ? S_MONEY_OUTER
                                                      : S_MONEY_EATER;
                end else if (disp_req && disp_expired) begin
                    disp_fault_n = 1'b1;
                    state_n      = S_MONEY_OUTER_ALL;
                end
            end
            S_MONEY_OUTER, S_MONEY_OUTER_ALL: begin
                coin_reject_n = coin_valid;
                if (credit < UNIT_C) begin
                    state_n = S_MONEY_EATER;
                end else if (chg_req && chg_ack) begin
                    credit_n = credit - UNIT_C;
                    if (credit == UNIT_C) state_n = S_MONEY_EATER;
                end
            end
            default: state_n = S_MONEY_EATER;
        endcase
        // Requests rise one cycle after the state calls for them.
        disp_req_n = (state == S_DRINK_OUTER) && (state_n == S_DRINK_OUTER);
        chg_req_n  = (state_n == S_MONEY_OUTER || state_n == S_MONEY_OUTER_ALL)
                  && (credit_n != '0) && !(chg_req && chg_ack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_MONEY_EATER;
            credit      <= '0;
            disp_req    <= 1'b0;
            chg_req     <= 1'b0;
            coin_reject <= 1'b0;
            vend_done   <= 1'b0;
            disp_fault  <= 1'b0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            disp_req    <= disp_req_n;
            chg_req     <= chg_req_n;
            coin_reject <= coin_reject_n;
            vend_done   <= vend_done_n;
            disp_fault  <= disp_fault_n;
        end
    end

    assign S_state = state;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl.
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_vend_ctrl;

    localparam int IDLE = 16;
    localparam int DISP = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_code = 2'b00;
    logic       buy = 1'b0;
    logic       cancel = 1'b0;
    logic       disp_req;
    logic       disp_ack = 1'b0;
    logic       chg_req;
    logic       chg_ack = 1'b0;
    logic [7:0] credit;
    logic [3:0] S_state;
    logic       coin_reject;
    logic       vend_done;
    logic       disp_fault;

    int n_cmp = 0;
    int n_bad = 0;
    int n_vend = 0;
    int n_fault = 0;
    int n_hs = 0;

    vend_ctrl #(
        .DRINK_VALUE  (25),
        .MAX_CREDIT   (100),
        .CREDIT_W     (8),
        .IDLE_TIMEOUT (IDLE),
        .DISP_TIMEOUT (DISP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin_code   (coin_code),
        .buy         (buy),
        .cancel      (cancel),
        .disp_req    (disp_req),
        .disp_ack    (disp_ack),
        .chg_req     (chg_req),
        .chg_ack     (chg_ack),
        .credit      (credit),
        .S_state     (S_state),
        .coin_reject (coin_reject),
        .vend_done   (vend_done),
        .disp_fault  (disp_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vend_done) n_vend <= n_vend + 1;
        if (disp_fault) n_fault <= n_fault + 1;
        if (chg_req && chg_ack) n_hs <= n_hs + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_valid = 1'b1;
        coin_code  = c;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic press_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic press_buy();
        buy = 1'b1;
        tick();
        buy = 1'b0;
    endtask

    task automatic serve_change(output int coins, output bit done);
        coins = 0;
        done  = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (chg_req) begin
                chg_ack = 1'b1;
                tick();
                chg_ack = 1'b0;
                coins++;
            end else begin
                tick();
            end
            if (S_state == 4'b0001 && !chg_req) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (S_state !== 4'b0001) begin n_bad++; $display("FAIL reset_state got %b want 0001", S_state); end
        n_cmp++; if (credit !== 8'd0) begin n_bad++; $display("FAIL reset_credit got %0d want 0", credit); end
        n_cmp++; if ({disp_req, chg_req} !== 2'b00) begin n_bad++; $display("FAIL reset_reqs got %b want 00", {disp_req, chg_req}); end
        n_cmp++; if ({coin_reject, vend_done, disp_fault} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got %b want 000", {coin_reject, vend_done, disp_fault}); end
    endtask

    task automatic test_purchase();
        int v0, h0, coins;
        bit done;
        v0 = n_vend;
        h0 = n_hs;
        coin(2'b10);
        n_cmp++; if (credit !== 8'd20) begin n_bad++; $display("FAIL buy_coin20 got %0d want 20", credit); end
        coin(2'b01);
        n_cmp++; if (credit !== 8'd30) begin n_bad++; $display("FAIL buy_coin10 got %0d want 30", credit); end
        press_buy();
        n_cmp++; if ({S_state, disp_req} !== 5'b0010_0) begin n_bad++; $display("FAIL buy_entry got %b want 00100", {S_state, disp_req}); end
        tick();
        n_cmp++; if (disp_req !== 1'b1) begin n_bad++; $display("FAIL buy_dispreq got %b want 1", disp_req); end
        tick();
        tick();
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        n_cmp++; if (credit !== 8'd5) begin n_bad++; $display("FAIL buy_remainder got %0d want 5", credit); end
        n_cmp++; if ({S_state, vend_done, disp_req, chg_req} !== 7'b0100_1_0_1) begin n_bad++; $display("FAIL buy_after_ack got %b want 0100101", {S_state, vend_done, disp_req, chg_req}); end
        serve_change(coins, done);
        n_cmp++; if (done !== 1'b1 || coins !== 1) begin n_bad++; $display("FAIL buy_change got %0d coins done=%b want 1 coins done=1", coins, done); end
        tick();
        tick();
        n_cmp++; if ({S_state, credit} !== {4'b0001, 8'd0}) begin n_bad++; $display("FAIL buy_end got %b/%0d want 0001/0", S_state, credit); end
        n_cmp++; if (n_vend - v0 !== 1 || n_hs - h0 !== 1) begin n_bad++; $display("FAIL buy_counts got vend=%0d hs=%0d want 1/1", n_vend - v0, n_hs - h0); end
    endtask

    task automatic test_overflow();
        int coins;
        bit done;
        coin(2'b11);
        coin(2'b11);
        n_cmp++; if (credit !== 8'd100) begin n_bad++; $display("FAIL ovf_full got %0d want 100", credit); end
        coin(2'b00);
        n_cmp++; if ({coin_reject, credit} !== {1'b1, 8'd100}) begin n_bad++; $display("FAIL ovf_reject got %b/%0d want 1/100", coin_reject, credit); end
        tick();
        n_cmp++; if (coin_reject !== 1'b0) begin n_bad++; $display("FAIL ovf_pulse got %b want 0", coin_reject); end
        press_cancel();
        n_cmp++; if (S_state !== 4'b1000) begin n_bad++; $display("FAIL ovf_cancel got %b want 1000", S_state); end
        serve_change(coins, done);
        n_cmp++; if (done !== 1'b1 || coins !== 20 || credit !== 8'd0) begin n_bad++; $display("FAIL ovf_refund got %0d coins credit %0d want 20/0", coins, credit); end
    endtask

    task automatic test_ignored();
        int coins;
        bit done;
        coin(2'b10);
        press_buy();
        tick();
        n_cmp++; if ({S_state, credit} !== {4'b0001, 8'd20}) begin n_bad++; $display("FAIL low_buy got %b/%0d want 0001/20", S_state, credit); end
        press_cancel();
        serve_change(coins, done);
        n_cmp++; if (done !== 1'b1 || coins !== 4) begin n_bad++; $display("FAIL low_refund got %0d want 4", coins); end
        coin(2'b01);
        coin_valid = 1'b1;
        coin_code  = 2'b00;
        cancel     = 1'b1;
        tick();
        coin_valid = 1'b0;
        cancel     = 1'b0;
        n_cmp++; if ({coin_reject, S_state, credit} !== {1'b1, 4'b1000, 8'd10}) begin n_bad++; $display("FAIL same_cycle got %b/%b/%0d want 1/1000/10", coin_reject, S_state, credit); end
        serve_change(coins, done);
        n_cmp++; if (done !== 1'b1 || coins !== 2) begin n_bad++; $display("FAIL same_refund got %0d want 2", coins); end
    endtask

    task automatic test_disp_fault();
        int f0, wait_cyc, coins;
        bit done;
        f0 = n_fault;
        coin(2'b10);
        coin(2'b00);
        press_buy();
        wait_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            wait_cyc++;
            if (disp_fault) break;
        end
        n_cmp++; if (disp_fault !== 1'b1) begin n_bad++; $display("FAIL fault_seen got %b want 1", disp_fault); end
        n_cmp++; if (wait_cyc < DISP || wait_cyc > DISP + 4) begin n_bad++; $display("FAIL fault_time got %0d want %0d..%0d", wait_cyc, DISP, DISP + 4); end
        n_cmp++; if ({S_state, credit, disp_req} !== {4'b1000, 8'd25, 1'b0}) begin n_bad++; $display("FAIL fault_state got %b/%0d/%b want 1000/25/0", S_state, credit, disp_req); end
        serve_change(coins, done);
        n_cmp++; if (done !== 1'b1 || coins !== 5 || credit !== 8'd0) begin n_bad++; $display("FAIL fault_refund got %0d coins credit %0d want 5/0", coins, credit); end
        n_cmp++; if (n_fault - f0 !== 1) begin n_bad++; $display("FAIL fault_count got %0d want 1", n_fault - f0); end
    endtask

    task automatic test_idle();
        int h0, v0, idle_cyc, coins;
        bit done;
        h0 = n_hs;
        v0 = n_vend;
        coin(2'b01);
        idle_cyc = 0;
        disp_ack = 1'b1;
        chg_ack  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_cyc++;
        end
        disp_ack = 1'b0;
        chg_ack  = 1'b0;
        n_cmp++; if ({S_state, credit} !== {4'b0001, 8'd10}) begin n_bad++; $display("FAIL spurious_ack got %b/%0d want 0001/10", S_state, credit); end
        n_cmp++; if (n_hs - h0 !== 0 || n_vend - v0 !== 0) begin n_bad++; $display("FAIL spurious_count got hs=%0d vend=%0d want 0/0", n_hs - h0, n_vend - v0); end
        for (int i = 0; i < 100; i++) begin
            if (S_state == 4'b1000) break;
            tick();
            idle_cyc++;
        end
        n_cmp++; if (S_state !== 4'b1000) begin n_bad++; $display("FAIL idle_timeout got %b want 1000", S_state); end
        n_cmp++; if (idle_cyc < IDLE || idle_cyc > IDLE + 2) begin n_bad++; $display("FAIL idle_time got %0d want %0d..%0d", idle_cyc, IDLE, IDLE + 2); end
        serve_change(coins, done);
        n_cmp++; if (done !== 1'b1 || coins !== 2) begin n_bad++; $display("FAIL idle_refund got %0d want 2", coins); end
    endtask

    task automatic test_reset_mid();
        int h0;
        coin(2'b01);
        coin(2'b00);
        press_cancel();
        n_cmp++; if ({S_state, credit, chg_req} !== {4'b1000, 8'd15, 1'b1}) begin n_bad++; $display("FAIL mid_payout got %b/%0d/%b want 1000/15/1", S_state, credit, chg_req); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({S_state, credit, chg_req} !== {4'b0001, 8'd0, 1'b0}) begin n_bad++; $display("FAIL mid_reset got %b/%0d/%b want 0001/0/0", S_state, credit, chg_req); end
        h0 = n_hs;
        tick();
        tick();
        n_cmp++; if ({chg_req, credit} !== {1'b0, 8'd0} || n_hs - h0 !== 0) begin n_bad++; $display("FAIL mid_after got %b/%0d hs=%0d want 0/0/0", chg_req, credit, n_hs - h0); end
    endtask

    initial begin
        test_reset();
        test_purchase();
        test_overflow();
        test_ignored();
        test_disp_fault();
        test_idle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
